// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the decoder's LSU request and a req/gnt/rvalid
// data-memory port. Stalls the core while an access is outstanding, builds
// byte enables and lane-replicated store data, extends load data, and
// reports misaligned accesses and bus timeouts.
//
// Bus handshake: o_mem_req is held high in REQ with every bus output stable
// from registered values until a cycle where i_mem_gnt=1 is seen at the
// rising edge; after that, i_mem_rvalid=1 at a rising edge in RSP completes
// the access. gnt is only looked at in REQ and rvalid only in RSP.
//
// o_dbg_state encoding: 0=IDLE, 1=REQ, 2=RSP, 3=DONE.
module lsu_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lsu_vld,
  input  logic        i_st_mem,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_ld_vld,
  output logic [31:0] o_ld_data,
  output logic        o_misalign,
  output logic        o_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic             we_q;
  logic [29:0]      waddr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [31:0]      ld_data_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic        misalign_now;
  logic [3:0]  be_now;
  logic [31:0] wdata_now;
  logic [31:0] shifted;
  logic [31:0] ld_fmt;
  logic        timeout_hit;
  logic        accept;
  logic        capture_rsp;
  logic        set_err;

  // The counter saturates at the limit, so a late grant cannot wrap it and
  // the limit test stays a simple equality.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Request decode: alignment check, byte enables and replicated store data.
  always_comb begin
    misalign_now = 1'b0;
    be_now       = 4'b1111;
    wdata_now    = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        be_now    = 4'b0001 << i_addr[1:0];
        wdata_now = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        misalign_now = i_addr[0];
        be_now       = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_now    = {2{i_wdata[15:0]}};
      end
      default: begin
        misalign_now = |i_addr[1:0];
      end
    endcase
  end

  // Load formatting: pick the addressed lane, then sign/zero-extend.
  always_comb begin
    shifted = i_mem_rdata >> {off_q, 3'b000};
    ld_fmt  = i_mem_rdata;
    case (f3_q[1:0])
      2'b00:   ld_fmt = {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   ld_fmt = {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]};
      default: ld_fmt = i_mem_rdata;
    endcase
  end

  // Next-state and control outputs.
  always_comb begin
    state_d     = state_q;
    o_stall     = 1'b0;
    o_misalign  = 1'b0;
    o_mem_req   = 1'b0;
    o_ld_vld    = 1'b0;
    accept      = 1'b0;
    capture_rsp = 1'b0;
    set_err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_lsu_vld) begin
          if (misalign_now) begin
            o_misalign = 1'b1;
          end else begin
            accept  = 1'b1;
            o_stall = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        o_mem_req = 1'b1;
        o_stall   = 1'b1;
        if (i_mem_gnt) begin
          state_d = S_RSP;
        end else if (timeout_hit) begin
          set_err = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RSP: begin
        o_stall = 1'b1;
        if (i_mem_rvalid) begin
          capture_rsp = 1'b1;
          state_d     = S_DONE;
        end else if (timeout_hit) begin
          set_err = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        o_ld_vld = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Access registers: captured on accept, result captured on completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q      <= 1'b0;
      waddr_q   <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      ld_data_q <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      we_q      <= i_st_mem;
      waddr_q   <= i_addr[31:2];
      be_q      <= be_now;
      wdata_q   <= wdata_now;
      f3_q      <= i_funct3;
      off_q     <= i_addr[1:0];
      ld_data_q <= '0;
      err_q     <= 1'b0;
    end else if (capture_rsp) begin
      ld_data_q <= we_q ? 32'd0 : ld_fmt;
      err_q     <= 1'b0;
    end else if (set_err) begin
      ld_data_q <= '0;
      err_q     <= 1'b1;
    end
  end

  // Timeout counter: cleared on entry to REQ, counts REQ and RSP cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if ((state_q == S_REQ || state_q == S_RSP) && !timeout_hit) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_mem_we    = we_q;
  assign o_mem_addr  = {waddr_q, 2'b00};
  assign o_mem_be    = be_q;
  assign o_mem_wdata = wdata_q;
  assign o_ld_data   = (state_q == S_DONE) ? ld_data_q : 32'd0;
  assign o_err       = (state_q == S_DONE) & err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_lsu_vld = 1'b0;
  logic        i_st_mem = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        o_stall, o_ld_vld, o_misalign, o_err;
  logic [31:0] o_ld_data;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_gnt = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic [1:0]  o_dbg_state;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  int hs_exp = 0;
  logic [31:0] exp_q[$];

  lsu_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_lsu_vld(i_lsu_vld), .i_st_mem(i_st_mem), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_ld_vld(o_ld_vld), .o_ld_data(o_ld_data),
    .o_misalign(o_misalign), .o_err(o_err),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_dbg_state(o_dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Count accepted bus requests to catch dropped or duplicated ones.
  always @(posedge clk) if (rst_n && o_mem_req && i_mem_gnt) hs_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model, straight from the access rules.
  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = m_size(f3);
    int mask = (1 << sz) - 1;
    if (sz == 4) return 4'hF;
    return 4'((mask << (a % 4)) & 15);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    int sz = m_size(f3);
    if (sz == 1) return (w & 32'hFF) * 32'h01010101;
    if (sz == 2) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int sz = m_size(f3);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Driver: one complete access with gnt after gdly REQ cycles and rvalid
  // after rdly RSP cycles, checking every cycle against the model.
  task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int gdly, input int rdly);
    logic mis;
    logic to;
    logic granted;
    int n;
    mis = m_mis(f3, addr);
    @(negedge clk);
    i_lsu_vld = 1'b1; i_st_mem = st; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    #1;
    chk("acc_misalign", o_misalign, mis);
    chk("acc_stall", o_stall, !mis);
    chk("acc_req", o_mem_req, 0);
    @(negedge clk);
    i_lsu_vld = 1'b0;
    if (mis) begin
      chk("mis_req", o_mem_req, 0);
      chk("mis_stall", o_stall, 0);
      chk("mis_state", o_dbg_state, 0);
      return;
    end
    n = 0; to = 1'b0; granted = 1'b0;
    for (int k = 0; k < TO; k++) begin
      chk("req_req", o_mem_req, 1);
      chk("req_stall", o_stall, 1);
      chk("req_addr", o_mem_addr, {addr[31:2], 2'b00});
      chk("req_be", o_mem_be, m_be(f3, addr));
      chk("req_we", o_mem_we, st);
      if (st) chk("req_wdata", o_mem_wdata, m_wdata(f3, wdata));
      if (k == gdly) begin
        i_mem_gnt = 1'b1;
        hs_exp++;
        @(negedge clk);
        i_mem_gnt = 1'b0;
        n++;
        granted = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (!granted) to = 1'b1;
    else begin
      for (int k = 0; k < TO; k++) begin
        chk("rsp_req", o_mem_req, 0);
        chk("rsp_stall", o_stall, 1);
        chk("rsp_vld", o_ld_vld, 0);
        if (k == rdly) begin
          i_mem_rvalid = 1'b1; i_mem_rdata = rdata;
          @(negedge clk);
          i_mem_rvalid = 1'b0; i_mem_rdata = $urandom;
          break;
        end
        if (n >= TO - 1) begin
          @(negedge clk);
          to = 1'b1;
          break;
        end
        @(negedge clk);
        n++;
      end
    end
    exp_q.push_back((st || to) ? 32'd0 : m_load(f3, addr, rdata));
    // DONE: request input is ignored even if misaligned.
    i_lsu_vld = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_0003;
    #1;
    chk("done_vld", o_ld_vld, 1);
    chk("done_stall", o_stall, 0);
    chk("done_err", o_err, to);
    chk("done_data", o_ld_data, exp_q.pop_front());
    chk("done_mis", o_misalign, 0);
    chk("done_req", o_mem_req, 0);
    @(negedge clk);
    i_lsu_vld = 1'b0;
    #1;
    chk("post_state", o_dbg_state, 0);
    chk("post_vld", o_ld_vld, 0);
    chk("post_err", o_err, 0);
  endtask

  // Accept a lw and walk into REQ (rsp=0) or RSP (rsp=1), then reset.
  task automatic reset_mid(input logic rsp);
    @(negedge clk);
    i_lsu_vld = 1'b1; i_st_mem = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0200;
    @(negedge clk);
    i_lsu_vld = 1'b0;
    chk("rm_req_before", o_mem_req, 1);
    if (rsp) begin
      i_mem_gnt = 1'b1;
      hs_exp++;
      @(negedge clk);
      i_mem_gnt = 1'b0;
      chk("rm_in_rsp", o_dbg_state, 2);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rm_req", o_mem_req, 0);
    chk("rm_stall", o_stall, 0);
    chk("rm_state", o_dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rm_no_vld", o_ld_vld, 0);
    end
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", o_dbg_state, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_req", o_mem_req, 0);
    chk("rst_vld", o_ld_vld, 0);
    chk("rst_data", o_ld_data, 0);
    chk("rst_be", o_mem_be, 0);
    chk("rst_addr", o_mem_addr, 0);
    rst_n = 1'b1;

    // Directed cases
    do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0);
    do_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1, 0);
    do_access(1'b0, 3'b101, 32'h102, 32'h0, 32'hBEEF1234, 0, 2);
    do_access(1'b1, 3'b001, 32'h002, 32'h0000ABCD, 32'h0, 4, 1);
    do_access(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
    do_access(1'b1, 3'b001, 32'h001, 32'h1234, 32'h0, 0, 0);
    do_access(1'b0, 3'b010, 32'h300, 32'h0, 32'h11223344, 100, 0);
    do_access(1'b0, 3'b010, 32'h304, 32'h0, 32'h55667788, TO - 1, 0);
    do_access(1'b0, 3'b001, 32'h306, 32'h0, 32'h8001ABCD, 2, 100);

    // Reset mid-access, then normal traffic
    reset_mid(1'b0);
    reset_mid(1'b1);
    do_access(1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 0, 0);
    do_access(1'b1, 3'b010, 32'h404, 32'hA5A5_5A5A, 32'h0, 0, 0);
    do_access(1'b0, 3'b010, 32'h404, 32'h0, 32'h0BADCAFE, 0, 0);

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      logic st;
      logic [2:0] f3;
      int gd, rd;
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      gd = ($urandom_range(0, 7) == 0) ? 50 : $urandom_range(0, 3);
      rd = ($urandom_range(0, 7) == 0) ? 50 : $urandom_range(0, 3);
      do_access(st, f3, $urandom, $urandom, $urandom, gd, rd);
    end

    repeat (2) @(negedge clk);
    chk("handshakes", hs_cnt, hs_exp);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Multi-cycle load/store sequencer between the decoder's LSU request (lsu_VALID, st_mem, funct3) and a req/gnt/rvalid data-memory port. It stalls the core while an access is outstanding. It generates byte enables and replicated write data, and sign/zero-extends load data. It flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYC, 255, cycles spent in REQ+RSP before the access is aborted with o_err (must be >=2)
CNT_W, 8, timeout counter width (must hold TIMEOUT_CYC)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_lsu_vld  in  1  LSU request from the control decoder
i_st_mem  in  1  1=store, 0=load
i_funct3  in  3  inst[14:12]: size/sign of the access
i_addr  in  32  byte address (ALU result)
i_wdata  in  32  store data (rs2)
o_stall  out  1  freeze PC/pipeline
o_ld_vld  out  1  one-cycle completion pulse
o_ld_data  out  32  extended load data, valid with o_ld_vld
o_misalign  out  1  misaligned access, one-cycle, no bus traffic
o_err  out  1  timeout, one-cycle, coincident with o_ld_vld
o_mem_req  out  1  bus request
o_mem_we  out  1  write enable
o_mem_addr  out  32  word address {addr[31:2],2'b00}
o_mem_be  out  4  byte enables
o_mem_wdata  out  32  lane-replicated write data
i_mem_gnt  in  1  request accepted
i_mem_rvalid  in  1  response (read data or write ack)
i_mem_rdata  in  32  read data

Behaviour:
- States: IDLE, REQ, RSP, DONE. Reset value: IDLE. All outputs and registers are 0 at reset; the counter is 0. Reset mid-access aborts immediately: o_mem_req drops asynchronously and no o_ld_vld is produced.
- Misalign: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0.
- funct3: bit2 selects zero-extension for loads. Size 00 is byte, 01 is half. Any other size is treated as word.
- IDLE, i_lsu_vld=1, misaligned: o_misalign=1 that cycle (combinational). No stall, no request, stay in IDLE.
- IDLE, i_lsu_vld=1, aligned: o_stall=1 combinationally that cycle. Register we, word address, be, wdata, funct3 and addr[1:0], then go to REQ.
- REQ: o_mem_req=1 with all bus outputs held stable from the registered values. i_mem_gnt=1 goes to RSP.
- RSP: o_mem_req=0. i_mem_rvalid=1 registers the formatted data (loads) and goes to DONE. rvalid together with gnt in the same cycle is not allowed; gnt is sampled only in REQ and rvalid only in RSP.
- DONE: o_stall=0, o_ld_vld=1, o_ld_data=registered value (0 for stores). i_lsu_vld is ignored (same instruction). Next state is IDLE.
- o_stall is 1 in REQ, RSP, and IDLE-accepting cycles, and 0 otherwise.
- Timeout: the counter clears on entering REQ and increments each REQ/RSP cycle. At count==TIMEOUT_CYC-1 without the exiting handshake, go to DONE with o_err=1 and o_ld_data=0. A handshake in that same cycle wins: normal completion, o_err=0.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
  - loads drive the same be.
- Write data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load data:
  - byte = rdata[8*addr[1:0]+:8]
  - half = rdata[16*addr[1]+:16]
  - sign- or zero-extend per funct3[2]; word is passed through.
- Minimum aligned access latency: accept -> REQ -> RSP -> DONE = 3 stall cycles with immediate gnt/rvalid.

Test Plan:
- lw x, addr 0x100, gnt in the first REQ cycle, rvalid=0xDEADBEEF the next cycle -> o_mem_addr 0x100, be 1111, stall for 3 cycles, then o_ld_vld=1 with data 0xDEADBEEF.
- lb at 0x103 with rdata 0x80FFFFFF -> be 1000, data 0xFFFFFF80. lbu at the same address -> 0x00000080. lhu at 0x102 with rdata 0xBEEF1234 -> 0x0000BEEF.
- sh at 0x002, wdata 0x0000ABCD -> we=1, be 1100, wdata 0xABCDABCD. gnt delayed 4 cycles: bus outputs stable throughout, stall held until rvalid, o_ld_data=0.
- lw at 0x101 -> o_misalign=1 for one cycle, o_mem_req never asserted, o_stall=0. sh at 0x001 behaves the same.
- TIMEOUT_CYC=8, gnt never asserted -> o_mem_req for 8 cycles, then o_err=1 and o_ld_vld=1 with data 0, state back to IDLE. Repeat with gnt on cycle 8 -> normal completion, no error.
- i_rst_n pulsed low while in RSP -> o_mem_req and o_stall go to 0 at once, state IDLE. A new lw after reset completes normally. Back-to-back sw then lw -> no dropped or duplicated request.
